// File: rtl/amo_dmem_arbiter.sv
// amo_dmem_arbiter: shares one data-memory port between the LSU and the AMO
// unit. An AMO read locks the port until its write-back, so the
// read-modify-write is atomic against LSU traffic. A watchdog drops a lock
// that is never completed and pulses amo_abort.
module amo_dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [3:0]            lsu_mask,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic                  amo_rd_en,
  input  logic                  amo_wr_en,
  input  logic [ADDR_WIDTH-1:0] amo_addr,
  input  logic [DATA_WIDTH-1:0] amo_wdata,
  output logic                  amo_gnt,
  output logic                  amo_rvalid,
  output logic [DATA_WIDTH-1:0] amo_rdata,
  output logic                  amo_abort,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_mask,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [7:0] CNT_LAST = 8'(LOCK_TIMEOUT - 1);

  state_t                  state, state_nxt;
  logic [7:0]              lock_cnt, lock_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   lock_addr;
  logic                    last_amo;     // 1: AMO won the last contested grant
  logic                    rd_pend_lsu, rd_pend_amo;
  logic                    lsu_rd_gnt, amo_rd_gnt;
  logic                    conflict;

  // Two requesters competing for the port from IDLE.
  assign conflict = (state == IDLE) && lsu_req && amo_rd_en;

  // Grant selection, memory mux, lock watchdog and next state.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    lsu_gnt      = 1'b0;
    amo_gnt      = 1'b0;
    amo_abort    = 1'b0;
    lsu_rd_gnt   = 1'b0;
    amo_rd_gnt   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_mask     = 4'b0000;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (lsu_req && (!amo_rd_en || last_amo)) begin
            lsu_gnt    = 1'b1;
            lsu_rd_gnt = !lsu_we;
            mem_req    = 1'b1;
            mem_we     = lsu_we;
            mem_addr   = lsu_addr;
            mem_wdata  = lsu_wdata;
            mem_mask   = lsu_mask;
          end else if (amo_rd_en) begin
            amo_gnt      = 1'b1;
            amo_rd_gnt   = 1'b1;
            mem_req      = 1'b1;
            mem_addr     = amo_addr;
            mem_mask     = 4'b1111;
            lock_cnt_nxt = '0;
            state_nxt    = LOCK;
          end
          // a lone amo_wr_en in IDLE has no lock to write back: ignored
        end
        LOCK: begin
          // write-back beats a same-cycle timeout
          if (amo_wr_en) begin
            amo_gnt   = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = lock_addr;
            mem_wdata = amo_wdata;
            mem_mask  = 4'b1111;
            state_nxt = IDLE;
          end else if (lock_cnt == CNT_LAST) begin
            amo_abort = 1'b1;
            state_nxt = IDLE;
          end else begin
            lock_cnt_nxt = lock_cnt + 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, lock bookkeeping, round-robin history and read-return tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      lock_addr   <= '0;
      last_amo    <= 1'b1;
      rd_pend_lsu <= 1'b0;
      rd_pend_amo <= 1'b0;
    end else begin
      state       <= state_nxt;
      lock_cnt    <= lock_cnt_nxt;
      if (amo_rd_gnt) lock_addr <= amo_addr;
      if (conflict)   last_amo  <= amo_gnt;
      rd_pend_lsu <= lsu_rd_gnt;
      rd_pend_amo <= amo_rd_gnt;
    end
  end

  // Return data is shared; rvalid steers it. Suppressed while in reset so a
  // read granted just before reset never reports data.
  assign lsu_rvalid = rd_pend_lsu && !rst;
  assign amo_rvalid = rd_pend_amo && !rst;
  assign lsu_rdata  = mem_rdata;
  assign amo_rdata  = mem_rdata;

endmodule

// File: tb/tb_amo_dmem_arbiter.sv
// Directed bench for amo_dmem_arbiter with a scoreboard: expected read data
// and memory writes are queued as stimulus is issued; a monitor pops and
// compares whenever the DUT shows rvalid or a memory write.
module tb_amo_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_mask;
  logic        lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        amo_rd_en, amo_wr_en;
  logic [31:0] amo_addr, amo_wdata;
  logic        amo_gnt, amo_rvalid, amo_abort;
  logic [31:0] amo_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  logic [31:0] lsu_q[$];
  logic [31:0] amo_q[$];
  wr_t         wr_q[$];
  bit   [31:0] mem [bit [31:0]];

  int n_vec = 0;
  int n_err = 0;
  int n_abort = 0;

  amo_dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .amo_rd_en(amo_rd_en), .amo_wr_en(amo_wr_en), .amo_addr(amo_addr),
    .amo_wdata(amo_wdata), .amo_gnt(amo_gnt), .amo_rvalid(amo_rvalid),
    .amo_rdata(amo_rdata), .amo_abort(amo_abort),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: always ready, 1-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (rst) begin
      mem[32'h100] = 32'hDEADBEEF;
      mem[32'h40]  = 32'd5;
    end else if (mem_req) begin
      if (mem_we) begin
        bit [31:0] w;
        w = mem[mem_addr];
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
        mem[mem_addr] = w;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (amo_abort) n_abort++;
      if (lsu_rvalid) begin
        if (lsu_q.size() == 0) chk("lsu_rvalid_unexpected", {31'd0, lsu_rvalid}, 32'd0);
        else chk("lsu_rdata", lsu_rdata, lsu_q.pop_front());
      end
      if (amo_rvalid) begin
        if (amo_q.size() == 0) chk("amo_rvalid_unexpected", {31'd0, amo_rvalid}, 32'd0);
        else chk("amo_rdata", amo_rdata, amo_q.pop_front());
      end
      if (mem_req && mem_we) begin
        if (wr_q.size() == 0) chk("mem_write_unexpected", {31'd0, mem_we}, 32'd0);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_mask", {28'd0, mem_mask}, {28'd0, e.mask});
        end
      end
    end
  endtask

  task automatic lsu_rd(input logic [31:0] a);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = a; lsu_wdata = '0; lsu_mask = 4'b1111;
  endtask

  initial begin
    rst = 1'b1;
    lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; lsu_mask = 0;
    amo_rd_en = 0; amo_wr_en = 0; amo_addr = 0; amo_wdata = 0;
    fork monitor(); join_none

    // reset: requests present but nothing granted
    cyc(); cyc();
    lsu_rd(32'h100);
    @(negedge clk);
    chk("rst_lsu_gnt", {31'd0, lsu_gnt}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_abort", {31'd0, amo_abort}, 0);

    // LSU read of 0x100
    cyc(); rst = 1'b0; lsu_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("lsu_gnt_rd", {31'd0, lsu_gnt}, 1);
    chk("lsu_rd_addr", mem_addr, 32'h100);
    chk("lsu_rd_we", {31'd0, mem_we}, 0);
    cyc(); lsu_req = 1'b0;
    @(negedge clk);
    chk("idle_mem_req", {31'd0, mem_req}, 0);
    chk("idle_mem_addr", mem_addr, 0);

    // first conflict: LSU wins
    cyc(); lsu_rd(32'h100); amo_rd_en = 1'b1; amo_addr = 32'h40;
    lsu_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("c1_lsu_gnt", {31'd0, lsu_gnt}, 1);
    chk("c1_amo_gnt", {31'd0, amo_gnt}, 0);
    cyc(); lsu_req = 1'b0; amo_q.push_back(32'd5);
    @(negedge clk);
    chk("c1_amo_gnt_next", {31'd0, amo_gnt}, 1);
    chk("amo_rd_addr", mem_addr, 32'h40);
    chk("amo_rd_mask", {28'd0, mem_mask}, 32'hF);

    // LOCK: LSU blocked, amo_addr change ignored, then write-back
    cyc(); amo_rd_en = 1'b0; amo_addr = 32'h80; lsu_rd(32'h100);
    @(negedge clk);
    chk("lock_lsu_gnt", {31'd0, lsu_gnt}, 0);
    chk("lock_mem_req", {31'd0, mem_req}, 0);
    cyc(); amo_wr_en = 1'b1; amo_wdata = 32'd8;
    wr_q.push_back('{addr: 32'h40, data: 32'd8, mask: 4'hF});
    @(negedge clk);
    chk("wb_amo_gnt", {31'd0, amo_gnt}, 1);
    chk("wb_lsu_gnt", {31'd0, lsu_gnt}, 0);
    cyc(); amo_wr_en = 1'b0; lsu_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("post_wb_lsu_gnt", {31'd0, lsu_gnt}, 1);

    // second conflict: AMO wins; reads back the value just written
    cyc(); lsu_rd(32'h100); amo_rd_en = 1'b1; amo_addr = 32'h40;
    amo_q.push_back(32'd8);
    @(negedge clk);
    chk("c2_amo_gnt", {31'd0, amo_gnt}, 1);
    chk("c2_lsu_gnt", {31'd0, lsu_gnt}, 0);

    // timeout: never write back, abort in the 4th LOCK cycle
    cyc(); amo_rd_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("to_abort_c%0d", i), {31'd0, amo_abort}, (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_mem_req_c%0d", i), {31'd0, mem_req}, 0);
      chk($sformatf("to_lsu_gnt_c%0d", i), {31'd0, lsu_gnt}, 0);
      if (i != 4) cyc();
    end
    cyc(); amo_wr_en = 1'b1; amo_wdata = 32'h55; lsu_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("to_idle_lsu_gnt", {31'd0, lsu_gnt}, 1);
    chk("to_wr_amo_gnt", {31'd0, amo_gnt}, 0);
    cyc(); lsu_req = 1'b0;
    @(negedge clk);
    chk("stray_wr_amo_gnt", {31'd0, amo_gnt}, 0);
    chk("stray_wr_mem_req", {31'd0, mem_req}, 0);
    chk("abort_count", n_abort, 1);

    // reset mid-lock
    cyc(); amo_wr_en = 1'b0; amo_rd_en = 1'b1; amo_addr = 32'h40;
    @(negedge clk);
    chk("rml_amo_gnt", {31'd0, amo_gnt}, 1);
    cyc(); rst = 1'b1; amo_rd_en = 1'b0; lsu_rd(32'h100);
    @(negedge clk);
    chk("rml_amo_rvalid", {31'd0, amo_rvalid}, 0);
    chk("rml_lsu_gnt", {31'd0, lsu_gnt}, 0);
    chk("rml_mem_req", {31'd0, mem_req}, 0);
    cyc(); rst = 1'b0; lsu_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("rml_lsu_gnt_after", {31'd0, lsu_gnt}, 1);

    // back-to-back LSU: masked write, then two reads
    cyc(); lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h200;
    lsu_wdata = 32'h12345678; lsu_mask = 4'b0011;
    wr_q.push_back('{addr: 32'h200, data: 32'h12345678, mask: 4'b0011});
    @(negedge clk);
    chk("b2b_wr_gnt", {31'd0, lsu_gnt}, 1);
    cyc(); lsu_rd(32'h200); lsu_q.push_back(32'h00005678);
    @(negedge clk);
    chk("b2b_rd1_gnt", {31'd0, lsu_gnt}, 1);
    cyc(); lsu_rd(32'h100); lsu_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("b2b_rd2_gnt", {31'd0, lsu_gnt}, 1);
    cyc(); lsu_req = 1'b0;

    repeat (6) cyc();
    chk("abort_count_final", n_abort, 1);
    chk("lsu_q_drained", lsu_q.size(), 0);
    chk("amo_q_drained", amo_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/amo_dmem_arbiter.md
# amo_dmem_arbiter

Shares the single data-memory port between the pipeline load/store unit (LSU) and the AMO unit. Once an AMO read is granted, the port stays locked to the AMO unit until its write-back, so the read-modify-write is atomic with respect to LSU traffic. A watchdog counter releases a lock that is never completed. The block sits between the LSU/AMO memory request buses and the data memory.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- LOCK_TIMEOUT, 15, maximum number of cycles in LOCK without an AMO write; valid range 2..255
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- lsu_req  in  1  LSU request
- lsu_we  in  1  LSU write (1) or read (0)
- lsu_addr  in  ADDR_WIDTH  LSU address
- lsu_wdata  in  DATA_WIDTH  LSU write data
- lsu_mask  in  4  LSU byte mask
- lsu_gnt  out  1  LSU request accepted this cycle
- lsu_rvalid  out  1  LSU read data valid
- lsu_rdata  out  DATA_WIDTH  LSU read data
- amo_rd_en  in  1  AMO locking read request
- amo_wr_en  in  1  AMO write-back request
- amo_addr  in  ADDR_WIDTH  AMO address; sampled on the read grant only
- amo_wdata  in  DATA_WIDTH  AMO write data
- amo_gnt  out  1  AMO request accepted this cycle
- amo_rvalid  out  1  AMO read data valid; drives the AMO unit's is_data_loaded
- amo_rdata  out  DATA_WIDTH  AMO read data
- amo_abort  out  1  one-cycle pulse when the lock times out
- mem_req  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_mask  out  4  memory byte mask
- mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after a read request; the memory is always ready

## Operation
- The state machine has two states: IDLE and LOCK.
- **IDLE, only lsu_req:** grant the LSU. The memory signals are driven combinationally from the lsu_* inputs.
- **IDLE, only amo_rd_en:** grant the AMO unit. Issue a read with mask 4'b1111. Capture amo_addr into lock_addr. Clear lock_cnt. Move to LOCK.
- **IDLE, both requesting:** round-robin. The requester that did not win the last contested grant wins. The last-winner register resets to "AMO", so the LSU wins the first conflict. Uncontested grants do not update the last-winner register.
- **IDLE, amo_wr_en without a lock:** not granted. No memory access results from it.
- **LOCK:**
  - lsu_gnt = 0 and amo_rd_en is ignored.
  - amo_wr_en is granted with mem_we=1, mem_addr=lock_addr, mem_wdata=amo_wdata, mask 4'b1111. The next state is IDLE.
- **LOCK, no amo_wr_en:** lock_cnt increments each cycle. If lock_cnt == LOCK_TIMEOUT-1 and there is no amo_wr_en:
  - next state IDLE;
  - amo_abort pulses in that cycle;
  - no memory access occurs.
- **Simultaneous amo_wr_en and timeout:** the write wins and there is no abort.
- **Read return routing:**
  - rd_pend_lsu and rd_pend_amo flops are set on a granted read and last 1 cycle.
  - x_rvalid = rd_pend_x.
  - lsu_rdata and amo_rdata are both wired to mem_rdata; consumers qualify them with rvalid.
- **Idle bus:** when nothing is granted, mem_req=0 and the other mem_* outputs are 0.

## Timing
- Grants are combinational, in the same cycle as the request. A requester holds its request until it sees its grant.
- Read latency is 1 cycle: a grant at t gives rvalid at t+1.
- The LSU may issue back-to-back requests, one per cycle.
- Minimum AMO sequence:
  - read granted at t;
  - amo_rvalid at t+1;
  - write granted at the earliest t+1;
  - the LSU can be granted again at t+2.
- LSU requests wait for the whole lock duration.
- **Reset (synchronous):** when rst is high at an edge, the following are set at that edge:
  - state=IDLE, lock_cnt=0, lock_addr=0, last-winner=AMO;
  - rd_pend_*=0, amo_abort=0.
- **During reset:** while rst=1, lsu_gnt, amo_gnt and mem_req are forced to 0.
- **Reset mid-lock:** the lock is dropped. No rvalid follows a read that was granted in the cycle before reset. No abort pulse is generated.

## Test plan
- **LSU read:** LSU read of address 0x100 with memory holding 0xDEADBEEF -> lsu_gnt at t, lsu_rvalid=1 and lsu_rdata=0xDEADBEEF at t+1, amo_rvalid=0.
- **Conflict:** lsu_req and amo_rd_en at 0x40 in the same IDLE cycle after reset:
  - the LSU is granted first;
  - the AMO read is granted on the next cycle;
  - on the next conflict from IDLE, the AMO unit wins.
- **Full AMO sequence:**
  - AMO read of 0x40 (memory holds 5), then amo_wr_en with amo_wdata=8 while lsu_req is held;
  - required: amo_rvalid with data 5, the write goes to 0x40 with data 8, lsu_gnt=0 throughout LOCK, and lsu_gnt=1 the cycle after the write.
- **Timeout:** with LOCK_TIMEOUT=4, lock and never write:
  - amo_abort pulses exactly once, in the 4th LOCK cycle;
  - the state returns to IDLE and no memory write occurs;
  - an amo_wr_en issued afterwards gets no grant.
- **Write ignores amo_addr:** during LOCK, amo_addr changes to 0x80 before the write -> mem_addr is still 0x40.
- **Reset mid-lock:** assert rst one cycle after an AMO read grant -> no rvalid, gnt=0 during reset, and an LSU request is granted immediately after rst falls.
